// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
// Holds the FSM state enum, master IDs and parameter defaults.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic MASTER0 = 1'b0;
    localparam logic MASTER1 = 1'b1;

    localparam int ACCESS_CYCLES_DEF = 2;
    localparam int ADDR_W_DEF        = 64;
    localparam int DATA_W_DEF        = 64;

    // Down-counter width; covers the full 1..15 access length range.
    localparam int CNT_W = 4;

endpackage

// File: rtl/ram_arbiter_if.sv
// Master request/ack signals plus the RAM control side of the arbiter.
// The bidirectional RAM data bus stays a plain port on the arbiter.
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    // Handshake: a master raises req (with we/addr/wdata) and holds it
    // until its one-cycle ack. The arbiter latches the command when it
    // grants, so the request fields may change once the access has begun.
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_ack;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_ack;

    logic [ADDR_W-1:0] bus_addr;
    logic              ram_cs;
    logic              ram_we;
    logic              ram_oe;
    logic              busy;
    logic              grant_id;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_rdata, m0_ack,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_rdata, m1_ack,
        input  bus_addr, ram_cs, ram_we, ram_oe, busy, grant_id
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_rdata, m0_ack,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_rdata, m1_ack,
        output bus_addr, ram_cs, ram_we, ram_oe, busy, grant_id
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin winner selection with a registered last-grant.
// Reset points the history at master 1 so master 0 wins the first tie.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic       any_req,
    output logic       winner
);

    logic last_q;

    always_comb begin
        any_req = |req;
        winner  = MASTER0;
        if (req[0] && req[1]) begin
            winner = ~last_q;
        end else if (req[1]) begin
            winner = MASTER1;
        end
    end

    // History only moves when a grant is actually committed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= MASTER1;
        end else if (take && any_req) begin
            last_q <= winner;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two masters onto one asynchronous-style RAM bus using an
// IDLE -> ACCESS (ACCESS_CYCLES long) -> DONE sequence per transfer.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    ram_arbiter_if.slave      mif,
    inout  wire  [DATA_W-1:0] bus_data,
    output arb_state_t        dbg_state
);

    if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
        $error("ram_arbiter: ACCESS_CYCLES must be within 1..15");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              latch_cmd;
    logic              capture_rd;

    logic              gid_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic              any_req;
    logic              winner;
    logic              in_access;
    logic              in_done;

    rr_arb2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     ({mif.m1_req, mif.m0_req}),
        .take    (state_q == IDLE),
        .any_req (any_req),
        .winner  (winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch_cmd  = 1'b0;
        capture_rd = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d   = ACCESS;
                    cnt_d     = CNT_LOAD;
                    latch_cmd = 1'b1;
                end
            end
            ACCESS: begin
                // Count reaching zero marks the last ACCESS cycle.
                if (cnt_q == '0) begin
                    state_d    = DONE;
                    capture_rd = ~we_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command copy taken at grant; later changes on the master side are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gid_q   <= MASTER0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (latch_cmd) begin
            gid_q   <= winner;
            we_q    <= (winner == MASTER1) ? mif.m1_we    : mif.m0_we;
            addr_q  <= (winner == MASTER1) ? mif.m1_addr  : mif.m0_addr;
            wdata_q <= (winner == MASTER1) ? mif.m1_wdata : mif.m0_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (capture_rd) begin
            if (gid_q == MASTER1) begin
                rdata1_q <= bus_data;
            end else begin
                rdata0_q <= bus_data;
            end
        end
    end

    assign in_access = (state_q == ACCESS);
    assign in_done   = (state_q == DONE);

    assign mif.ram_cs   = in_access;
    assign mif.ram_we   = in_access & we_q;
    assign mif.ram_oe   = in_access & ~we_q;
    assign mif.bus_addr = in_access ? addr_q : '0;
    assign mif.busy     = (state_q != IDLE);
    assign mif.grant_id = gid_q;

    assign mif.m0_ack   = in_done && (gid_q == MASTER0);
    assign mif.m1_ack   = in_done && (gid_q == MASTER1);
    assign mif.m0_rdata = rdata0_q;
    assign mif.m1_rdata = rdata1_q;

    assign bus_data  = (in_access && we_q) ? wdata_q : 'z;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed plus randomized bench for ram_arbiter, checked against a
// transaction-level model (round-robin rule, fixed latency, RAM function).
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // sel picks the active instance: 0 -> ACCESS_CYCLES=2, 1 -> ACCESS_CYCLES=1
    logic sel;
    int   cur_ac;
    logic last_gnt;
    logic [DW-1:0] exp_rd [2];

    logic          m_req   [2];
    logic          m_we    [2];
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];

    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if_a ();
    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if_b ();
    wire [DW-1:0] bus_a;
    wire [DW-1:0] bus_b;
    arb_state_t   dbg_a, dbg_b;

    ram_arbiter #(.ACCESS_CYCLES(2), .ADDR_W(AW), .DATA_W(DW)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .mif       (if_a),
        .bus_data  (bus_a),
        .dbg_state (dbg_a)
    );

    ram_arbiter #(.ACCESS_CYCLES(1), .ADDR_W(AW), .DATA_W(DW)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .mif       (if_b),
        .bus_data  (bus_b),
        .dbg_state (dbg_b)
    );

    assign if_a.m0_req   = !sel && m_req[0];
    assign if_a.m0_we    = m_we[0];
    assign if_a.m0_addr  = m_addr[0];
    assign if_a.m0_wdata = m_wdata[0];
    assign if_a.m1_req   = !sel && m_req[1];
    assign if_a.m1_we    = m_we[1];
    assign if_a.m1_addr  = m_addr[1];
    assign if_a.m1_wdata = m_wdata[1];
    assign if_b.m0_req   = sel && m_req[0];
    assign if_b.m0_we    = m_we[0];
    assign if_b.m0_addr  = m_addr[0];
    assign if_b.m0_wdata = m_wdata[0];
    assign if_b.m1_req   = sel && m_req[1];
    assign if_b.m1_we    = m_we[1];
    assign if_b.m1_addr  = m_addr[1];
    assign if_b.m1_wdata = m_wdata[1];

    // RAM contents as a pure function of address.
    function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
        if (a == 64'h100) return 64'hDEADBEEF_00000001;
        return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
    endfunction

    // RAM side: returns data on reads, parks the bus at 0 whenever the
    // arbiter is not expected to drive it, leaves it free during writes.
    assign bus_a = (if_a.ram_cs && if_a.ram_we) ? 'z :
                   ((if_a.ram_cs && if_a.ram_oe) ? ram_val(if_a.bus_addr) : '0);
    assign bus_b = (if_b.ram_cs && if_b.ram_we) ? 'z :
                   ((if_b.ram_cs && if_b.ram_oe) ? ram_val(if_b.bus_addr) : '0);

    logic          o_cs, o_we, o_oe, o_busy, o_gid, o_ack0, o_ack1;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_bus, o_rd0, o_rd1;

    always_comb begin
        o_cs   = sel ? if_b.ram_cs   : if_a.ram_cs;
        o_we   = sel ? if_b.ram_we   : if_a.ram_we;
        o_oe   = sel ? if_b.ram_oe   : if_a.ram_oe;
        o_busy = sel ? if_b.busy     : if_a.busy;
        o_gid  = sel ? if_b.grant_id : if_a.grant_id;
        o_ack0 = sel ? if_b.m0_ack   : if_a.m0_ack;
        o_ack1 = sel ? if_b.m1_ack   : if_a.m1_ack;
        o_addr = sel ? if_b.bus_addr : if_a.bus_addr;
        o_bus  = sel ? bus_b         : bus_a;
        o_rd0  = sel ? if_b.m0_rdata : if_a.m0_rdata;
        o_rd1  = sel ? if_b.m1_rdata : if_a.m1_rdata;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        m_req[m]   = 1'b1;
        m_we[m]    = we;
        m_addr[m]  = a;
        m_wdata[m] = d;
    endtask

    task automatic set_req_rand(input int m);
        set_req(m, 1'($urandom_range(0, 1)), {32'h0, $urandom},
                {$urandom, $urandom | 32'h1});
    endtask

    task automatic clear_reqs();
        for (int m = 0; m < 2; m++) begin
            m_req[m]   = 1'b0;
            m_we[m]    = 1'b0;
            m_addr[m]  = '0;
            m_wdata[m] = '0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1 ({tag, "_cs"},   o_cs,   1'b0);
        chk1 ({tag, "_we"},   o_we,   1'b0);
        chk1 ({tag, "_oe"},   o_oe,   1'b0);
        chk1 ({tag, "_busy"}, o_busy, 1'b0);
        chk1 ({tag, "_gid"},  o_gid,  1'b0);
        chk1 ({tag, "_ack0"}, o_ack0, 1'b0);
        chk1 ({tag, "_ack1"}, o_ack1, 1'b0);
        chk64({tag, "_addr"}, o_addr, 64'h0);
        chk64({tag, "_bus"},  o_bus,  64'h0);
        chk64({tag, "_rd0"},  o_rd0,  64'h0);
        chk64({tag, "_rd1"},  o_rd1,  64'h0);
    endtask

    // Entered at a sample point in an IDLE cycle with requests applied.
    // Returns at the DONE sample point; the caller advances into IDLE.
    task automatic do_access(input bit drop, input bit mid_change, output logic w);
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        if (m_req[0] && m_req[1]) w = ~last_gnt;
        else if (m_req[1])        w = 1'b1;
        else                      w = 1'b0;
        last_gnt = w;
        ewe = m_we[w];
        ea  = m_addr[w];
        ewd = m_wdata[w];
        chk1 ("idle_busy", o_busy, 1'b0);
        chk1 ("idle_cs",   o_cs,   1'b0);
        chk64("idle_addr", o_addr, 64'h0);
        chk64("idle_bus",  o_bus,  64'h0);
        for (int k = 0; k < cur_ac; k++) begin
            tick();
            chk1 ("acc_cs",   o_cs,   1'b1);
            chk1 ("acc_we",   o_we,   ewe);
            chk1 ("acc_oe",   o_oe,   ~ewe);
            chk64("acc_addr", o_addr, ea);
            chk1 ("acc_busy", o_busy, 1'b1);
            chk1 ("acc_gid",  o_gid,  w);
            chk1 ("acc_ack0", o_ack0, 1'b0);
            chk1 ("acc_ack1", o_ack1, 1'b0);
            chk64("acc_bus",  o_bus,  ewe ? ewd : ram_val(ea));
            if (mid_change && k == 0) m_addr[w] = 64'h200;
        end
        tick();
        chk1 ("done_cs",   o_cs,   1'b0);
        chk1 ("done_we",   o_we,   1'b0);
        chk1 ("done_oe",   o_oe,   1'b0);
        chk64("done_addr", o_addr, 64'h0);
        chk1 ("done_busy", o_busy, 1'b1);
        chk1 ("done_gid",  o_gid,  w);
        chk1 ("done_ack0", o_ack0, w == 1'b0);
        chk1 ("done_ack1", o_ack1, w == 1'b1);
        chk64("done_bus",  o_bus,  64'h0);
        if (!ewe) exp_rd[w] = ram_val(ea);
        chk64("rdata0", o_rd0, exp_rd[0]);
        chk64("rdata1", o_rd1, exp_rd[1]);
        if (drop) m_req[w] = 1'b0;
    endtask

    task automatic random_phase(input int n);
        logic w;
        for (int i = 0; i < n; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (!m_req[m] && $urandom_range(0, 1) == 1) set_req_rand(m);
            end
            if (!m_req[0] && !m_req[1]) set_req_rand(int'($urandom_range(0, 1)));
            do_access(1'b1, 1'b0, w);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            if (m_req[0] || m_req[1]) begin
                do_access(1'b1, 1'b0, w);
                tick();
            end
        end
    endtask

    initial begin
        logic w;
        sel      = 1'b0;
        cur_ac   = 2;
        last_gnt = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        clear_reqs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        chk64("reset_state", 64'(dbg_a), 64'(IDLE));
        reset = 1'b0;
        tick();

        // CPU read returning the marker word
        set_req(0, 1'b0, 64'h100, 64'h0);
        do_access(1'b1, 1'b0, w);
        tick();
        chk64("m0_read_marker", o_rd0, 64'hDEADBEEF_00000001);

        // loader write
        set_req(1, 1'b1, 64'h2000, 64'h1234);
        do_access(1'b1, 1'b0, w);
        tick();

        // address changed by the master after grant
        set_req(0, 1'b0, 64'h100, 64'h0);
        do_access(1'b1, 1'b1, w);
        tick();

        // both masters held high: grants alternate
        set_req(0, 1'b0, 64'h40, 64'h0);
        set_req(1, 1'b1, 64'h80, 64'hABCD);
        for (int i = 0; i < 4; i++) begin
            do_access(1'b0, 1'b0, w);
            if (i == 3) clear_reqs();
            tick();
        end

        random_phase(40);

        // reset during the second ACCESS cycle of an m0 read
        set_req(0, 1'b0, 64'h300, 64'h0);
        tick();
        tick();
        chk1("pre_reset_cs",  o_cs,  1'b1);
        chk1("pre_reset_gid", o_gid, 1'b0);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        set_req(0, 1'b0, 64'h500, 64'h0);
        set_req(1, 1'b1, 64'h600, 64'h5555);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk1("rst_hold_ack0", o_ack0, 1'b0);
            chk1("rst_hold_ack1", o_ack1, 1'b0);
            chk1("rst_hold_busy", o_busy, 1'b0);
        end
        last_gnt  = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        reset = 1'b0;
        do_access(1'b1, 1'b0, w);
        chk1("post_reset_first_grant", o_gid, 1'b0);
        tick();
        do_access(1'b1, 1'b0, w);
        tick();

        // single-cycle access instance
        clear_reqs();
        sel      = 1'b1;
        cur_ac   = 1;
        last_gnt = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        reset = 1'b1;
        tick();
        check_reset_outputs("reset_b");
        chk64("reset_b_state", 64'(dbg_b), 64'(IDLE));
        reset = 1'b0;
        tick();
        set_req(0, 1'b0, 64'h100, 64'h0);
        do_access(1'b1, 1'b0, w);
        tick();
        chk64("ac1_read_marker", o_rd0, 64'hDEADBEEF_00000001);
        random_phase(15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
